// File: rtl/cross_bar_pkg.sv
// Shared sizing, types and round-robin helper for the master/slave crossbar.
package cross_bar_pkg;

    localparam int unsigned MASTER_N = 2;
    localparam int unsigned SLAVE_N  = 2;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;

    localparam int unsigned SEL_W = (SLAVE_N > 1) ? $clog2(SLAVE_N) : 1;
    localparam int unsigned MST_W = (MASTER_N > 1) ? $clog2(MASTER_N) : 1;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [MST_W-1:0]  mst_idx_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Master index reached by stepping 'off' places after 'base', wrapping at MASTER_N.
    function automatic mst_idx_t rr_index(input mst_idx_t base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= MASTER_N) begin
            sum = sum - MASTER_N;
        end
        return MST_W'(sum);
    endfunction

endpackage

// File: rtl/cross_bar_arbiter.sv
// Per-slave round-robin arbiter with owner tracking; grant held from award until the slave acks.
module cross_bar_arbiter
    import cross_bar_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [MASTER_N-1:0] req_i,
    input  logic                ack_i,
    output logic [MASTER_N-1:0] grant_o
);

    arb_state_e             state_q, state_d;
    logic [MASTER_N-1:0]    grant_q, grant_d;
    mst_idx_t               owner_q, owner_d;
    mst_idx_t               ptr_q,   ptr_d;
    logic                   found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    // Returning to idle after an ack leaves one dead cycle, so the owner's stale req is never regranted.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        found   = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                for (int unsigned i = 0; i < MASTER_N; i++) begin
                    if (!found && req_i[rr_index(ptr_q, i)]) begin
                        found                       = 1'b1;
                        owner_d                     = rr_index(ptr_q, i);
                        grant_d                     = '0;
                        grant_d[rr_index(ptr_q, i)] = 1'b1;
                        state_d                     = ARB_BUSY;
                    end
                end
            end
            ARB_BUSY: begin
                if (ack_i) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    ptr_d   = rr_index(owner_q, 1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign grant_o = grant_q;

endmodule

// File: rtl/cross_bar.sv
// MASTER_N x SLAVE_N request/ack crossbar: top-address decode, per-slave arbitration, AND-OR muxes.
module cross_bar
    import cross_bar_pkg::*;
(
    input  logic                             clk,
    input  logic                             aresetn,
    input  logic [MASTER_N-1:0]              master_req,
    input  logic [MASTER_N-1:0][ADDR_W-1:0]  master_addr,
    input  logic [MASTER_N-1:0]              master_cmd,
    input  logic [MASTER_N-1:0][DATA_W-1:0]  master_wdata,
    output logic [MASTER_N-1:0]              master_ack,
    output logic [MASTER_N-1:0][DATA_W-1:0]  master_rdata,
    output logic [SLAVE_N-1:0]               slave_req,
    output logic [SLAVE_N-1:0][ADDR_W-1:0]   slave_addr,
    output logic [SLAVE_N-1:0]               slave_cmd,
    output logic [SLAVE_N-1:0][DATA_W-1:0]   slave_wdata,
    input  logic [SLAVE_N-1:0]               slave_ack,
    input  logic [SLAVE_N-1:0][DATA_W-1:0]   slave_rdata
);

    logic [SLAVE_N-1:0][MASTER_N-1:0] req_mat;
    logic [SLAVE_N-1:0][MASTER_N-1:0] grant;

    // Request matrix: a master requests only the slave selected by its top address bits.
    always_comb begin
        req_mat = '0;
        for (int unsigned s = 0; s < SLAVE_N; s++) begin
            for (int unsigned m = 0; m < MASTER_N; m++) begin
                req_mat[s][m] = master_req[m] &&
                                (master_addr[m][ADDR_W-1 -: SEL_W] == SEL_W'(s));
            end
        end
    end

    for (genvar gs = 0; gs < SLAVE_N; gs++) begin : g_arb
        cross_bar_arbiter u_arb (
            .clk     (clk),
            .rst_n   (aresetn),
            .req_i   (req_mat[gs]),
            .ack_i   (slave_ack[gs]),
            .grant_o (grant[gs])
        );
    end

    // One-hot grants make AND-OR muxing sufficient; everything ungranted reads as zero.
    always_comb begin
        slave_req    = '0;
        slave_addr   = '0;
        slave_cmd    = '0;
        slave_wdata  = '0;
        master_ack   = '0;
        master_rdata = '0;
        for (int unsigned s = 0; s < SLAVE_N; s++) begin
            for (int unsigned m = 0; m < MASTER_N; m++) begin
                slave_req[s]    = slave_req[s] | grant[s][m];
                slave_addr[s]   = slave_addr[s] | (master_addr[m] & {ADDR_W{grant[s][m]}});
                slave_cmd[s]    = slave_cmd[s] | (master_cmd[m] & grant[s][m]);
                slave_wdata[s]  = slave_wdata[s] | (master_wdata[m] & {DATA_W{grant[s][m]}});
                master_ack[m]   = master_ack[m] | (grant[s][m] & slave_ack[s]);
                master_rdata[m] = master_rdata[m] |
                                  (slave_rdata[s] & {DATA_W{grant[s][m] & slave_ack[s]}});
            end
        end
    end

endmodule

// File: tb/tb_cross_bar.sv
// Self-checking bench for cross_bar: transaction-level model, per-cycle compare, directed scenarios.
module tb_cross_bar;
    import cross_bar_pkg::*;

    logic                             clk = 1'b0;
    logic                             aresetn = 1'b0;
    logic [MASTER_N-1:0]              master_req = '0;
    logic [MASTER_N-1:0][ADDR_W-1:0]  master_addr = '0;
    logic [MASTER_N-1:0]              master_cmd = '0;
    logic [MASTER_N-1:0][DATA_W-1:0]  master_wdata = '0;
    logic [MASTER_N-1:0]              master_ack;
    logic [MASTER_N-1:0][DATA_W-1:0]  master_rdata;
    logic [SLAVE_N-1:0]               slave_req;
    logic [SLAVE_N-1:0][ADDR_W-1:0]   slave_addr;
    logic [SLAVE_N-1:0]               slave_cmd;
    logic [SLAVE_N-1:0][DATA_W-1:0]   slave_wdata;
    logic [SLAVE_N-1:0]               slave_ack = '0;
    logic [SLAVE_N-1:0][DATA_W-1:0]   slave_rdata = {32'hBAD0_0001, 32'hBAD0_0000};

    cross_bar dut (
        .clk(clk), .aresetn(aresetn),
        .master_req(master_req), .master_addr(master_addr), .master_cmd(master_cmd),
        .master_wdata(master_wdata), .master_ack(master_ack), .master_rdata(master_rdata),
        .slave_req(slave_req), .slave_addr(slave_addr), .slave_cmd(slave_cmd),
        .slave_wdata(slave_wdata), .slave_ack(slave_ack), .slave_rdata(slave_rdata)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Transaction model: each slave is either free (-1) or owned by a master index.
    int own [SLAVE_N] = '{default: -1};
    int ptr [SLAVE_N] = '{default: 0};

    function automatic int target_of(input logic [ADDR_W-1:0] a);
        return int'(a >> (ADDR_W - SEL_W));
    endfunction

    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int s = 0; s < SLAVE_N; s++) begin own[s] = -1; ptr[s] = 0; end
        end else begin
            for (int s = 0; s < SLAVE_N; s++) begin
                if (own[s] >= 0) begin
                    if (slave_ack[s]) begin ptr[s] = (own[s] + 1) % MASTER_N; own[s] = -1; end
                end else begin
                    for (int k = 0; k < MASTER_N; k++) begin
                        if (own[s] < 0 && master_req[(ptr[s] + k) % MASTER_N] &&
                            target_of(master_addr[(ptr[s] + k) % MASTER_N]) == s)
                            own[s] = (ptr[s] + k) % MASTER_N;
                    end
                end
            end
        end
    end

    // Agents: masters drop req after an ack; slaves ack after a programmable latency.
    bit          m_drop [MASTER_N] = '{default: 0};
    int          m_done [MASTER_N] = '{default: 0};
    int          s_lat  [SLAVE_N]  = '{default: 1};
    int          s_cnt  [SLAVE_N]  = '{default: 0};
    logic [31:0] s_rd   [SLAVE_N]  = '{default: 32'h0};

    int cyc = 0;
    int prev_own0 = -1;
    int gr_who[$];
    int gr_cyc[$];
    int ack_cyc[$];

    always @(negedge clk) begin
        logic [65:0]       exp_s;
        logic              exp_ack;
        logic [DATA_W-1:0] exp_rd;
        cyc++;
        for (int s = 0; s < SLAVE_N; s++) begin
            exp_s = (own[s] >= 0) ? {1'b1, master_addr[own[s]], master_cmd[own[s]], master_wdata[own[s]]} : '0;
            chk($sformatf("slave%0d_port", s), {slave_req[s], slave_addr[s], slave_cmd[s], slave_wdata[s]}, exp_s);
        end
        for (int m = 0; m < MASTER_N; m++) begin
            exp_ack = 1'b0;
            exp_rd  = '0;
            for (int s = 0; s < SLAVE_N; s++) begin
                if (own[s] == m && slave_ack[s]) begin exp_ack = 1'b1; exp_rd = slave_rdata[s]; end
            end
            chk($sformatf("master%0d_resp", m), {master_ack[m], master_rdata[m]}, {exp_ack, exp_rd});
            if (exp_ack) m_drop[m] = 1'b1;
        end
        if (own[0] >= 0 && prev_own0 < 0) begin gr_who.push_back(own[0]); gr_cyc.push_back(cyc); end
        if (own[0] >= 0 && slave_ack[0]) ack_cyc.push_back(cyc);
        prev_own0 = own[0];
    end

    always begin
        @(posedge clk); #1;
        if (!aresetn) begin
            slave_ack = '0;
            for (int m = 0; m < MASTER_N; m++) m_drop[m] = 1'b0;
            for (int s = 0; s < SLAVE_N; s++) s_cnt[s] = 0;
        end else begin
            for (int m = 0; m < MASTER_N; m++) begin
                if (m_drop[m]) begin master_req[m] = 1'b0; m_drop[m] = 1'b0; m_done[m]++; end
            end
            for (int s = 0; s < SLAVE_N; s++) begin
                if (slave_ack[s]) begin
                    slave_ack[s]   = 1'b0;
                    slave_rdata[s] = 32'hBAD0_0000 | 32'(s);
                end else if (slave_req[s]) begin
                    if (s_cnt[s] >= s_lat[s]) begin
                        slave_ack[s] = 1'b1; slave_rdata[s] = s_rd[s]; s_cnt[s] = 0;
                    end else s_cnt[s]++;
                end else s_cnt[s] = 0;
            end
        end
    end

    task automatic issue(input int m, input logic [31:0] a, input logic c, input logic [31:0] d);
        master_addr[m] = a; master_cmd[m] = c; master_wdata[m] = d; master_req[m] = 1'b1;
    endtask

    task automatic wait_done(input int m, input int target);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (m_done[m] >= target) return;
        end
        chk("done_timeout", 128'(m_done[m]), 128'(target));
    endtask

    task automatic wait_sack(input int s);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (slave_ack[s]) return;
        end
        chk("slave_ack_timeout", 0, 1);
    endtask

    int base0, base1;

    initial begin
        // Reset: everything quiet, even with nonzero slave_rdata present.
        repeat (2) @(negedge clk);
        chk("rst_slave_req", slave_req, 0);
        chk("rst_slave_bus", {slave_addr, slave_cmd, slave_wdata}, 0);
        chk("rst_master", {master_ack, master_rdata}, 0);
        @(posedge clk); #2 aresetn = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_slave_req", slave_req, 0);

        // Stray slave_ack while idle must not reach any master.
        @(posedge clk); #3 slave_ack[1] = 1'b1;
        @(negedge clk);
        chk("idle_ack_ignored", master_ack, 0);

        // Single write M0 -> S0.
        s_lat[0] = 1;
        @(posedge clk); #1 issue(0, 32'h0000_0010, 1'b1, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("wr_latency_pre", slave_req, 0);
        @(negedge clk);
        chk("wr_slave_req", slave_req, 2'b01);
        chk("wr_slave0_fields", {slave_addr[0], slave_cmd[0], slave_wdata[0]}, {32'h0000_0010, 1'b1, 32'hDEAD_BEEF});
        wait_sack(0);
        chk("wr_master_ack", master_ack, 2'b01);
        wait_done(0, 1);

        // Read M1 -> S1 with returned data.
        s_lat[1] = 2; s_rd[1] = 32'h1234_5678;
        @(posedge clk); #1 issue(1, 32'h8000_0004, 1'b0, 32'h0);
        @(negedge clk); @(negedge clk);
        chk("rd_slave1_fields", {slave_req, slave_addr[1], slave_cmd[1]}, {2'b10, 32'h8000_0004, 1'b0});
        wait_sack(1);
        chk("rd_master_ack", master_ack, 2'b10);
        chk("rd_master1_rdata", master_rdata[1], 32'h1234_5678);
        chk("rd_master0_rdata", master_rdata[0], 0);
        wait_done(1, 1);

        // Parallel: different slaves granted on the same edge, independent acks.
        s_lat[0] = 1; s_lat[1] = 3; s_rd[1] = 32'hCAFE_0001;
        @(posedge clk); #1;
        issue(0, 32'h0000_0020, 1'b1, 32'h0000_AAAA);
        issue(1, 32'h8000_0030, 1'b0, 32'h0);
        @(negedge clk); @(negedge clk);
        chk("par_both_req", slave_req, 2'b11);
        wait_done(0, 2);
        wait_done(1, 2);

        // Reset while S0 is busy: outputs drop at once, transaction abandoned.
        s_lat[0] = 20;
        @(posedge clk); #1 issue(0, 32'h0000_0050, 1'b1, 32'h5555_5555);
        @(negedge clk); @(negedge clk);
        chk("mid_busy", slave_req, 2'b01);
        #2 aresetn = 1'b0;
        #1;
        chk("mid_rst_slave_req", slave_req, 0);
        chk("mid_rst_master_ack", master_ack, 0);
        master_req = '0;
        repeat (2) @(posedge clk);
        #2 aresetn = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", slave_req, 0);

        // Continuous contention on S0: pointer restarts at M0, then alternates.
        s_lat[0] = 0;
        gr_who.delete(); gr_cyc.delete(); ack_cyc.delete();
        base0 = m_done[0]; base1 = m_done[1];
        @(posedge clk); #1;
        fork
            begin
                for (int k = 0; k < 2; k++) begin
                    issue(0, 32'h0000_0100, 1'b1, 32'hA000_0000 + 32'(k));
                    wait_done(0, base0 + k + 1);
                    @(posedge clk); #1;
                end
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    issue(1, 32'h0000_0200, 1'b0, 32'h0);
                    wait_done(1, base1 + k + 1);
                    @(posedge clk); #1;
                end
            end
        join
        chk("rr_grant_count", 128'(gr_who.size()), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), 128'(gr_who[i]), 128'(i % 2));
        chk("rr_idle_gap", 128'(gr_cyc[1] - ack_cyc[0]), 2);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
